// File: rtl/t_line_pkg.sv
// Shared definitions for the toggle-coded serial line (tx today, rx later):
// FSM state encoding and the frame-length helper.
package t_line_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  // Bit-cycles per frame: start + data + optional parity + stop.
  function automatic int frame_len(input int data_w, input bit parity_en);
    return data_w + 2 + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/t_line_tx_t_ff_model.sv
// T flip-flop model of the receiver: q flips on every clock where t=1.
module t_ff_model (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!reset) q <= 1'b0;
    else        q <= q ^ t;
  end

endmodule

// File: rtl/t_line_tx.sv
// Toggle-line transmitter: START(1), DATA LSB first, optional PARITY, STOP(0), GAP.
// Optional even-parity bit enabled by defining T_LINE_PARITY_EN.
module t_line_tx
  import t_line_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              t,
  output logic              q_line,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  // Handshake: a word moves when in_valid && in_ready at a rising edge;
  // in_ready is high only in IDLE while reset is released, and in_data is
  // captured on that edge and ignored at every other time.
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
`ifdef T_LINE_PARITY_EN
  logic              par;
`endif

  assign in_ready  = (state == S_IDLE) && reset;
  assign dbg_state = state;

  // Outputs are set for the state being entered, so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      t       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
`ifdef T_LINE_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
`ifdef T_LINE_PARITY_EN
            par   <= ^in_data;
`endif
            state <= S_START;
            t     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_DATA;
          t       <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        S_DATA: begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            bit_cnt <= '0;
`ifdef T_LINE_PARITY_EN
            state   <= S_PARITY;
            t       <= par;
`else
            state   <= S_STOP;
            t       <= 1'b0;
            done    <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            t       <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
`ifdef T_LINE_PARITY_EN
        S_PARITY: begin
          state <= S_STOP;
          t     <= 1'b0;
          done  <= 1'b1;
        end
`endif
        S_STOP: begin
          done <= 1'b0;
          t    <= 1'b0;
          if (GAP_CYC == 0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          t     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  t_ff_model u_rx_model (
    .clk   (clk),
    .reset (reset),
    .t     (t),
    .q     (q_line)
  );

endmodule

// File: tb/tb_t_line_tx.sv
// Directed bench for t_line_tx: three instances (GAP_CYC 1, 0, 3) checked against a frame scoreboard.
module tb_t_line_tx;
  import t_line_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] in_data  [3];
  logic       in_valid [3];
  logic       in_ready [3];
  logic       t        [3];
  logic       q_line   [3];
  logic       busy     [3];
  logic       done     [3];
  state_t     st       [3];

  logic [7:0] exp_q[$];
  bit         mq [3];
  int         passed = 0;
  int         total  = 0;

  t_line_tx #(.DATA_W(8), .GAP_CYC(1)) u_g1 (
    .clk(clk), .reset(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .t(t[0]), .q_line(q_line[0]), .busy(busy[0]),
    .done(done[0]), .dbg_state(st[0]));

  t_line_tx #(.DATA_W(8), .GAP_CYC(0)) u_g0 (
    .clk(clk), .reset(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .t(t[1]), .q_line(q_line[1]), .busy(busy[1]),
    .done(done[1]), .dbg_state(st[1]));

  t_line_tx #(.DATA_W(8), .GAP_CYC(3)) u_g3 (
    .clk(clk), .reset(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .t(t[2]), .q_line(q_line[2]), .busy(busy[2]),
    .done(done[2]), .dbg_state(st[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[dut%0d]: got %0h expected %0h", tag, k, obs, exp);
  endtask

  // Caller is in the START cycle; checks every bit, ending in the STOP cycle.
  task automatic check_frame(input int k, input logic [7:0] d);
    logic [7:0] e;
    exp_q.push_back(8'd1);
    for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, d[i]});
`ifdef T_LINE_PARITY_EN
    exp_q.push_back({7'd0, ^d});
`endif
    exp_q.push_back(8'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("t", k, {7'd0, t[k]}, e);
      chk("done", k, {7'd0, done[k]}, (exp_q.size() == 0) ? 8'd1 : 8'd0);
      chk("busy", k, {7'd0, busy[k]}, 8'd1);
      chk("in_ready_busy", k, {7'd0, in_ready[k]}, 8'd0);
      if (exp_q.size() == 0) chk("q_line_stop", k, {7'd0, q_line[k]}, {7'd0, mq[k]});
      if (e[0]) mq[k] = ~mq[k];
      in_data[k] = 8'($urandom_range(0, 255));
      if (exp_q.size() > 0) tick;
    end
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!in_ready[k] && n < 40) begin
      tick;
      n++;
    end
    chk("ready_wait", k, {7'd0, in_ready[k]}, 8'd1);
  endtask

  task automatic send(input int k, input logic [7:0] d);
    wait_ready(k);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    tick;
    in_valid[k] = 1'b0;
    check_frame(k, d);
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data[k]  = 8'h00;
      in_valid[k] = 1'b0;
      mq[k]       = 1'b0;
    end

    // 1: reset held 3 cycles, then release
    tick;
    chk("in_ready_in_reset", 0, {7'd0, in_ready[0]}, 8'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      chk("t_rst", k, {7'd0, t[k]}, 8'd0);
      chk("q_rst", k, {7'd0, q_line[k]}, 8'd0);
      chk("busy_rst", k, {7'd0, busy[k]}, 8'd0);
      chk("done_rst", k, {7'd0, done[k]}, 8'd0);
      chk("in_ready_rst", k, {7'd0, in_ready[k]}, 8'd1);
      chk("state_rst", k, 8'(st[k]), 8'(S_IDLE));
    end

    // 2/3: 0xA5 then 0x01, plus a few random words, on GAP_CYC=1
    send(0, 8'hA5);
    chk("q_after_a5", 0, {7'd0, mq[0]}, 8'd1);
    send(0, 8'h01);
    for (int r = 0; r < 3; r++) send(0, 8'($urandom_range(0, 255)));
    tick;
    chk("gap_t", 0, {7'd0, t[0]}, 8'd0);
    chk("gap_busy", 0, {7'd0, busy[0]}, 8'd1);

    // 4: back-to-back on GAP_CYC=0 with in_valid held high
    wait_ready(1);
    in_valid[1] = 1'b1;
    in_data[1]  = 8'hFF;
    tick;
    check_frame(1, 8'hFF);
    in_data[1] = 8'h00;
    tick;
    chk("b2b_idle_ready", 1, {7'd0, in_ready[1]}, 8'd1);
    chk("b2b_idle_busy", 1, {7'd0, busy[1]}, 8'd0);
    chk("b2b_idle_t", 1, {7'd0, t[1]}, 8'd0);
    tick;
    in_valid[1] = 1'b0;
    check_frame(1, 8'h00);

    // 6: GAP_CYC=3, in_valid held while busy
    wait_ready(2);
    in_valid[2] = 1'b1;
    in_data[2]  = 8'h3C;
    tick;
    check_frame(2, 8'h3C);
    for (int g = 0; g < 3; g++) begin
      tick;
      chk("gap3_ready", 2, {7'd0, in_ready[2]}, 8'd0);
      chk("gap3_t", 2, {7'd0, t[2]}, 8'd0);
      chk("gap3_busy", 2, {7'd0, busy[2]}, 8'd1);
    end
    in_data[2] = 8'h81;
    tick;
    chk("gap3_idle_ready", 2, {7'd0, in_ready[2]}, 8'd1);
    tick;
    in_valid[2] = 1'b0;
    check_frame(2, 8'h81);

    // 5: reset during the 4th data bit, then a clean frame
    wait_ready(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    tick;
    in_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    chk("state_d3", 0, 8'(st[0]), 8'(S_DATA));
    chk("t_d3", 0, {7'd0, t[0]}, 8'd0);
    rst = 1'b0;
    tick;
    chk("abort_t", 0, {7'd0, t[0]}, 8'd0);
    chk("abort_q", 0, {7'd0, q_line[0]}, 8'd0);
    chk("abort_busy", 0, {7'd0, busy[0]}, 8'd0);
    chk("abort_state", 0, 8'(st[0]), 8'(S_IDLE));
    chk("abort_ready", 0, {7'd0, in_ready[0]}, 8'd0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) mq[k] = 1'b0;
    #1;
    chk("rel_ready", 0, {7'd0, in_ready[0]}, 8'd1);
    send(0, 8'h5A);

    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
